// File: rtl/t_netlist_sched.sv
// Round-robin scheduler sharing one +1 incrementer across 4 requesters; done arrives n+2 cycles after capture.
// Optional macro T_NETLIST_SCHED_CHECK_EN adds a shadow result check that blocks passed and stops on mismatch.
module t_netlist_sched #(
   parameter int WIDTH = 5,
   parameter int NREQ  = 4
) (
   input  logic                  fastclk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*3-1:0]     req_n,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            done_id,
   output logic [WIDTH-1:0]      result,
   output logic                  passed
);

   typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc;
   logic [2:0]       cnt;
   logic [1:0]       id;
   logic [1:0]       ptr;
   logic [2:0]       done_cnt;
   logic             sel_vld;
   logic [1:0]       sel_id;
   logic [1:0]       rr_idx;
   logic [WIDTH-1:0] sel_a;
   logic [2:0]       sel_n;
   logic             check_ok;

   // Search starts one past the last grant so a waiting requester is never skipped twice.
   always_comb begin
      sel_vld = 1'b0;
      sel_id  = ptr;
      rr_idx  = ptr;
      for (int k = 1; k <= NREQ; k++) begin
         rr_idx = ptr + 2'(k);
         if (!sel_vld && req[rr_idx]) begin
            sel_vld = 1'b1;
            sel_id  = rr_idx;
         end
      end
   end

   assign sel_a = req_a[int'(sel_id)*WIDTH +: WIDTH];
   assign sel_n = req_n[int'(sel_id)*3 +: 3];
   assign busy  = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_vld) state_nxt = STEP;
         STEP:    if (cnt == 3'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         cnt      <= '0;
         id       <= '0;
         ptr      <= 2'd3;
         gnt      <= '0;
         done     <= 1'b0;
         done_id  <= '0;
         result   <= '0;
         done_cnt <= '0;
         passed   <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= '0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  acc         <= sel_a;
                  cnt         <= sel_n;
                  id          <= sel_id;
                  ptr         <= sel_id;
                  gnt[sel_id] <= 1'b1;
               end
            end
            STEP: begin
               if (cnt != 3'd0) begin
                  acc <= acc + 1'b1;
                  cnt <= cnt - 3'd1;
               end
            end
            DONE: begin
               done    <= 1'b1;
               result  <= acc;
               done_id <= id;
               if (done_cnt != 3'd6) done_cnt <= done_cnt + 3'd1;
               if (done_cnt == 3'd5 && check_ok) passed <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef T_NETLIST_SCHED_CHECK_EN
   logic [WIDTH-1:0] expected;
   logic             err;

   assign check_ok = !err && (acc == expected);

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         expected <= '0;
         err      <= 1'b0;
      end else begin
         if (state == IDLE && sel_vld) expected <= sel_a + WIDTH'(sel_n);
         if (state == DONE && acc != expected) begin
            err <= 1'b1;
            $display("t_netlist_sched: mismatch");
            $stop;
         end
      end
   end
`else
   assign check_ok = 1'b1;
`endif

endmodule

// File: tb/tb_t_netlist_sched.sv
// Scoreboard bench for t_netlist_sched: expected completions queued at stimulus time, popped at done.
module tb_t_netlist_sched;
   localparam int WIDTH = 5;
   localparam int NREQ  = 4;

   logic             fastclk = 1'b0;
   logic             reset;
   logic [3:0]       req;
   logic [19:0]      req_a;
   logic [11:0]      req_n;
   logic [3:0]       gnt;
   logic             busy, done, passed;
   logic [1:0]       done_id;
   logic [4:0]       result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] id;
      logic [4:0] res;
      int         lat;
   } exp_t;
   exp_t sb[$];

   t_netlist_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .fastclk(fastclk), .reset(reset), .req(req), .req_a(req_a), .req_n(req_n),
      .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result), .passed(passed)
   );

   always #5 fastclk = ~fastclk;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge fastclk);
      #1;
   endtask

   // Drives one request and measures grant and completion; comparisons are left to the caller.
   task automatic do_op(input int i, input logic [4:0] a, input logic [2:0] n,
                        output logic [3:0] g0, output logic [3:0] g1, output int lat,
                        output logic [1:0] did, output logic [4:0] res, output logic bsy);
      req_a[i*5 +: 5] = a;
      req_n[i*3 +: 3] = n;
      req[i] = 1'b1;
      tick();
      g0 = gnt;
      req[i] = 1'b0;
      g1 = 'x; did = 'x; res = 'x; bsy = 'x;
      lat = 0;
      while (lat < 30) begin
         tick();
         lat++;
         if (lat == 1) g1 = gnt;
         if (done) begin
            did = done_id;
            res = result;
            bsy = busy;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      checks++; if (gnt !== 4'b0)     begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id got %0d want 0", done_id); end
      checks++; if (result !== 5'd0)  begin errors++; $display("FAIL reset_result got %0d want 0", result); end
      checks++; if (passed !== 1'b0)  begin errors++; $display("FAIL reset_passed got %b want 0", passed); end
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic;
      int         ids[5] = '{0, 0, 0, 2, 3};
      logic [4:0] as[5]  = '{5'd1, 5'd31, 5'd9, 5'd20, 5'd30};
      logic [2:0] ns[5]  = '{3'd4, 3'd1, 3'd0, 3'd7, 3'd5};
      logic [3:0] g0, g1;
      logic [1:0] did;
      logic [4:0] res;
      logic       bsy;
      int         lat;
      exp_t       e, x;
      for (int k = 0; k < 5; k++) begin
         e.id  = 2'(ids[k]);
         e.res = 5'(as[k] + 5'(ns[k]));
         e.lat = int'(ns[k]) + 2;
         sb.push_back(e);
         do_op(ids[k], as[k], ns[k], g0, g1, lat, did, res, bsy);
         x = sb.pop_front();
         checks++; if (g0 !== (4'b1 << x.id)) begin errors++; $display("FAIL basic%0d_gnt got %b want %b", k, g0, 4'b1 << x.id); end
         checks++; if (g1 !== 4'b0)  begin errors++; $display("FAIL basic%0d_gnt_pulse got %b want 0000", k, g1); end
         checks++; if (lat !== x.lat) begin errors++; $display("FAIL basic%0d_latency got %0d want %0d", k, lat, x.lat); end
         checks++; if (did !== x.id)  begin errors++; $display("FAIL basic%0d_done_id got %0d want %0d", k, did, x.id); end
         checks++; if (res !== x.res) begin errors++; $display("FAIL basic%0d_result got %0d want %0d", k, res, x.res); end
         checks++; if (bsy !== 1'b0)  begin errors++; $display("FAIL basic%0d_busy_at_done got %b want 0", k, bsy); end
      end
      checks++; if (passed !== 1'b0) begin errors++; $display("FAIL passed_early got %b want 0", passed); end
   endtask

   task automatic test_passed;
      logic [3:0] g0, g1;
      logic [1:0] did;
      logic [4:0] res;
      logic       bsy;
      int         lat;
      exp_t       e, x;
      e.id = 2'd3; e.res = 5'd5; e.lat = 5;
      sb.push_back(e);
      do_op(3, 5'd2, 3'd3, g0, g1, lat, did, res, bsy);
      x = sb.pop_front();
      checks++; if (res !== x.res)   begin errors++; $display("FAIL sixth_result got %0d want %0d", res, x.res); end
      checks++; if (passed !== 1'b1) begin errors++; $display("FAIL passed_on_sixth got %b want 1", passed); end
      e.id = 2'd3; e.res = 5'd12; e.lat = 3;
      sb.push_back(e);
      do_op(3, 5'd11, 3'd1, g0, g1, lat, did, res, bsy);
      x = sb.pop_front();
      repeat (3) tick();
      checks++; if (res !== x.res)   begin errors++; $display("FAIL seventh_result got %0d want %0d", res, x.res); end
      checks++; if (passed !== 1'b1) begin errors++; $display("FAIL passed_sticky got %b want 1", passed); end
   endtask

   task automatic test_rr;
      int   order[5] = '{0, 1, 2, 3, 0};
      int   gi = 0;
      int   nd = 0;
      int   cyc = 0;
      exp_t e, x;
      for (int i = 0; i < 4; i++) begin
         req_a[i*5 +: 5] = 5'(i*7 + 1);
         req_n[i*3 +: 3] = 3'd1;
      end
      for (int k = 0; k < 5; k++) begin
         e.id  = 2'(order[k]);
         e.res = 5'(order[k]*7 + 2);
         e.lat = 3;
         sb.push_back(e);
      end
      req = 4'b1111;
      while (cyc < 100 && nd < 5) begin
         tick();
         cyc++;
         if (gnt !== 4'b0) begin
            if (gi < 5) begin
               checks++;
               if (gnt !== (4'b1 << order[gi])) begin errors++; $display("FAIL rr_grant%0d got %b want %b", gi, gnt, 4'b1 << order[gi]); end
            end else begin
               checks++; errors++; $display("FAIL rr_extra_grant got %b want none", gnt);
            end
            gi++;
         end
         if (done) begin
            x = sb.pop_front();
            checks++; if (done_id !== x.id) begin errors++; $display("FAIL rr_done_id%0d got %0d want %0d", nd, done_id, x.id); end
            checks++; if (result !== x.res) begin errors++; $display("FAIL rr_result%0d got %0d want %0d", nd, result, x.res); end
            nd++;
            if (nd == 5) req = 4'b0;
         end
      end
      req = 4'b0;
      checks++; if (nd !== 5) begin errors++; $display("FAIL rr_done_count got %0d want 5", nd); end
      checks++; if (gi !== 5) begin errors++; $display("FAIL rr_grant_count got %0d want 5", gi); end
      repeat (4) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_after got %b want 0", busy); end
   endtask

   task automatic test_drop;
      int   cyc = 0;
      int   nd = 0;
      int   ng = 0;
      exp_t e, x;
      e.id = 2'd0; e.res = 5'd7; e.lat = 9;
      sb.push_back(e);
      req_a[4:0] = 5'd0;
      req_n[2:0] = 3'd7;
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      req[2] = 1'b1;
      repeat (3) tick();
      req[2] = 1'b0;
      while (cyc < 30 && nd == 0) begin
         tick();
         cyc++;
         if (done) begin
            x = sb.pop_front();
            nd++;
            checks++; if (result !== x.res) begin errors++; $display("FAIL drop_result got %0d want %0d", result, x.res); end
         end
      end
      checks++; if (nd !== 1) begin errors++; $display("FAIL drop_done got %0d want 1", nd); end
      repeat (6) begin
         tick();
         if (gnt !== 4'b0 || busy !== 1'b0) ng++;
      end
      checks++; if (ng !== 0) begin errors++; $display("FAIL drop_ignored got %0d busy cycles want 0", ng); end
   endtask

   task automatic test_reset_mid;
      logic [3:0] g0, g1;
      logic [1:0] did;
      logic [4:0] res;
      logic       bsy;
      int         lat;
      int         nd = 0;
      exp_t       e, x;
      req_a[9:5] = 5'd10;
      req_n[5:3] = 3'd3;
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0;
      #1 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL midrst_done got %b want 0", done); end
      checks++; if (result !== 5'd0) begin errors++; $display("FAIL midrst_result got %0d want 0", result); end
      checks++; if (gnt !== 4'b0)    begin errors++; $display("FAIL midrst_gnt got %b want 0000", gnt); end
      checks++; if (passed !== 1'b0) begin errors++; $display("FAIL midrst_passed got %b want 0", passed); end
      tick();
      tick();
      reset = 1'b0;
      repeat (10) begin
         tick();
         if (done) nd++;
      end
      checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_stray_done got %0d want 0", nd); end
      e.id = 2'd0; e.res = 5'd6; e.lat = 4;
      sb.push_back(e);
      do_op(0, 5'd4, 3'd2, g0, g1, lat, did, res, bsy);
      x = sb.pop_front();
      checks++; if (g0 !== 4'b0001)  begin errors++; $display("FAIL fresh_gnt got %b want 0001", g0); end
      checks++; if (lat !== x.lat)   begin errors++; $display("FAIL fresh_latency got %0d want %0d", lat, x.lat); end
      checks++; if (res !== x.res)   begin errors++; $display("FAIL fresh_result got %0d want %0d", res, x.res); end
      checks++; if (did !== x.id)    begin errors++; $display("FAIL fresh_done_id got %0d want %0d", did, x.id); end
   endtask

   initial begin
      reset = 1'b0;
      req   = '0;
      req_a = '0;
      req_n = '0;
      test_reset();
      test_basic();
      test_passed();
      test_rr();
      test_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/t_netlist_sched.md
T_NETLIST_SCHED -- requirements
Module: t_netlist_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/result width in bits.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (design and bench fixed at 4).
REQ-003 SHALL have port fastclk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester request, level, held until granted.
REQ-006 SHALL have port req_a  input  NREQ*WIDTH  operands; requester i in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_n  input  NREQ*3  increment counts 0..7; requester i in bits [i*3 +: 3].
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, one-cycle pulse.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port done_id  output  2  index of the requester whose operation completed.
REQ-012 SHALL have port result  output  WIDTH  final accumulator value, held until next done.
REQ-013 SHALL have port passed  output  1  sticky self-test pass flag.

Function
REQ-014 SHALL share one +1 incrementer among all requesters; only one operation in flight at a time.
REQ-015 SHALL implement FSM states IDLE, STEP, DONE.
REQ-016 IDLE: if any req bit set, SHALL select round-robin starting at (last granted index + 1) mod 4, latch acc<=operand, cnt<=count, id<=index, update the pointer, and move to STEP.
REQ-017 gnt SHALL be high for exactly the cycle following the capturing edge, bit id only.
REQ-018 STEP: if cnt==0 SHALL move to DONE without incrementing; else acc<=acc+1 mod 2^WIDTH, cnt<=cnt-1, stay in STEP.
REQ-019 DONE: done=1, result<=acc, done_id<=id, next state IDLE; done SHALL occur n+2 cycles after the capturing edge.
REQ-020 Wrap-around SHALL be modular: operand 31, n=1 yields result 0.
REQ-021 Requests arriving while busy SHALL wait; a req dropped before its grant SHALL be ignored.
REQ-022 Simultaneous requests SHALL be served in rotating order, no requester granted twice while another waits.
REQ-023 SHALL count done pulses (saturating at 6) and set passed=1 when the sixth completes; passed then stays 1 until reset.

Reset
REQ-024 On reset assertion, independent of fastclk, state SHALL go IDLE; gnt, busy, done, done_id, result, passed, acc, cnt, done counter SHALL clear to 0.
REQ-025 Round-robin pointer SHALL reset to 3 so requester 0 has first priority.
REQ-026 Reset mid-operation SHALL abort it with no done pulse; first request after release starts fresh.

Configuration
REQ-027 Macro T_NETLIST_SCHED_CHECK_EN, when defined, SHALL capture expected=(operand+n) mod 2^WIDTH at grant, compare with acc in DONE, and on mismatch set a sticky error, block passed, print "t_netlist_sched: mismatch" and execute $stop.
REQ-028 Without T_NETLIST_SCHED_CHECK_EN, no shadow logic SHALL exist and passed SHALL depend only on the done count.

Verification
REQ-029 req=0001, a0=1, n0=4 -> gnt=0001 one cycle, done 6 cycles after capture, result=5, done_id=0.
REQ-030 req=0001, a0=31, n0=1 -> result=0; a0=9, n0=0 -> result=9, done 2 cycles after capture.
REQ-031 req=1111 held, all n=1 -> grants in order 0,1,2,3, then 0 again; no back-to-back grant to one requester while others wait.
REQ-032 reset asserted in STEP with cnt=3 -> busy, done, result=0 immediately; no done pulse after release.
REQ-033 six completed operations -> passed=1 on the sixth done, remains 1; with CHECK_EN and a forced acc corruption -> $stop, passed stays 0.
